// File: rtl/enc8to3_req_encoder.sv
// Sequential 8-to-3 request encoder: sticky pending vector, one index per valid/ready grant.
// Define ENC8TO3_ROUND_ROBIN_EN for rotating priority; default build is fixed priority (index 0 highest).
module enc8to3_req_encoder #(
    parameter int N_IN  = 8,
    parameter int W_OUT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [N_IN-1:0]  in,
    output logic [W_OUT-1:0] out,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [N_IN-1:0]  pending,
    output logic             overflow
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state;
    logic             hs;
    logic [N_IN-1:0]  acc_mask;
    logic [N_IN-1:0]  rem;
    logic [N_IN-1:0]  req;
    logic [W_OUT-1:0] sel;

    assign hs       = out_vld & out_rdy;
    assign acc_mask = hs ? (N_IN'(1) << out) : '0;
    // Only registered pending is a grant candidate; same-cycle requests wait one edge.
    assign rem      = pending & ~acc_mask;
    assign req      = en ? in : '0;

`ifdef ENC8TO3_ROUND_ROBIN_EN
    logic [W_OUT-1:0] last;
    logic [W_OUT-1:0] start;
    logic [W_OUT-1:0] idx;

    assign start = last + W_OUT'(1);

    // Scan from the farthest slot back to start so the first set bit after last wins.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = start + W_OUT'(k);
            if (rem[idx]) sel = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  last <= W_OUT'(N_IN - 1);
        else if (hs) last <= out;
    end
`else
    always_comb begin
        sel = '0;
        for (int k = N_IN - 1; k >= 0; k--)
            if (rem[k]) sel = W_OUT'(k);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            out      <= '0;
            out_vld  <= 1'b0;
            overflow <= 1'b0;
            state    <= IDLE;
        end else if (clr) begin
            pending  <= '0;
            out      <= '0;
            out_vld  <= 1'b0;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            // Set wins over accept, so a re-request of the granted bit is not a loss.
            pending <= rem | req;
            if (|(req & rem)) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        out     <= sel;
                        out_vld <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (hs) begin
                        if (|rem) begin
                            out <= sel;
                        end else begin
                            out_vld <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc8to3_req_encoder.sv
// Scoreboarded bench for enc8to3_req_encoder: expected grant indices queued at stimulus time,
// popped on every observed handshake; state outputs spot-checked between edges.
module tb_enc8to3_req_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       en;
    logic [7:0] in;
    logic [2:0] out;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    enc8to3_req_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .en       (en),
        .in       (in),
        .out      (out),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant monitor: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) chk("grant_unexpected", 32'(out), 32'hFFFF_FFFF);
            else                   chk("grant", 32'(out), 32'(exp_q.pop_front()));
        end
    end

    logic [2:0] seq3 [3];
    logic [2:0] seqff[8];

    initial begin
`ifdef ENC8TO3_ROUND_ROBIN_EN
        seq3  = '{3'd7, 3'd1, 3'd2};
        seqff = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
`else
        seq3  = '{3'd1, 3'd2, 3'd7};
        seqff = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; in = '0; out_rdy = 1'b0;
        #12;
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        #5 rst_n = 1'b1;
        step();

        // Ready with nothing valid does nothing.
        out_rdy = 1'b1;
        step(); step();
        chk("idle_rdy_vld", 32'(out_vld), 32'h0);
        chk("idle_rdy_pend", 32'(pending), 32'h0);

        // Single request: two-edge latency to out_vld.
        en = 1'b1; in = 8'h20; exp_q.push_back(3'd5);
        step(); in = '0;
        chk("single_pend", 32'(pending), 32'h20);
        chk("single_vld0", 32'(out_vld), 32'h0);
        step();
        chk("single_vld", 32'(out_vld), 32'h1);
        chk("single_out", 32'(out), 32'h5);
        step();
        chk("single_done_vld", 32'(out_vld), 32'h0);
        chk("single_done_pend", 32'(pending), 32'h0);

        // Multi-request back-to-back drain.
        in = 8'h86;
        foreach (seq3[i]) exp_q.push_back(seq3[i]);
        step(); in = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("multi_out", 32'(out), 32'(seq3[i]));
            chk("multi_vld", 32'(out_vld), 32'h1);
            step();
        end
        chk("multi_end_vld", 32'(out_vld), 32'h0);

        // Backpressure holds the presented index.
        out_rdy = 1'b0; in = 8'h08;
        step(); in = '0;
        step();
        chk("bp_out", 32'(out), 32'h3);
        in = 8'h01;
        step(); in = '0;
        chk("bp_pend", 32'(pending), 32'h09);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_out", 32'(out), 32'h3);
            chk("bp_hold_vld", 32'(out_vld), 32'h1);
        end
        exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        out_rdy = 1'b1;
        step();
        chk("bp_next_out", 32'(out), 32'h0);
        step();
        chk("bp_end_vld", 32'(out_vld), 32'h0);
        chk("bp_end_pend", 32'(pending), 32'h0);

        // Re-request of the bit being accepted: stays pending, no overflow.
        in = 8'h02; exp_q.push_back(3'd1);
        step(); in = '0;
        step();
        in = 8'h02; exp_q.push_back(3'd1);
        step(); in = '0;
        chk("setwin_pend", 32'(pending), 32'h02);
        chk("setwin_ovf", 32'(overflow), 32'h0);
        step();
        chk("setwin_out", 32'(out), 32'h1);
        step();
        chk("setwin_end_pend", 32'(pending), 32'h0);

        // Overflow then synchronous clear.
        out_rdy = 1'b0; in = 8'h10;
        step();
        chk("ovf_pre", 32'(overflow), 32'h0);
        step(); in = '0;
        chk("ovf_set", 32'(overflow), 32'h1);
        clr = 1'b1;
        step(); clr = 1'b0;
        chk("clr_pend", 32'(pending), 32'h0);
        chk("clr_vld", 32'(out_vld), 32'h0);
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_out", 32'(out), 32'h0);

        // Asynchronous reset mid-operation.
        in = 8'hA5;
        step(); step(); in = '0;
        chk("mid_pend", 32'(pending), 32'hA5);
        chk("mid_vld", 32'(out_vld), 32'h1);
        chk("mid_ovf", 32'(overflow), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pend", 32'(pending), 32'h0);
        chk("arst_vld", 32'(out_vld), 32'h0);
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_ovf", 32'(overflow), 32'h0);
        #3 rst_n = 1'b1;
        step();

        // Persistent two-source request: registered-only candidates alternate 0,4.
        in = 8'h11; out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(3'd0); exp_q.push_back(3'd4);
        end
        step(); step();
        chk("alt_first", 32'(out), 32'h0);
        for (int i = 0; i < 6; i++) step();
        out_rdy = 1'b0; en = 1'b0; in = '0;
        chk("alt_ovf", 32'(overflow), 32'h1);
        clr = 1'b1;
        step(); clr = 1'b0;

        // Full vector drain; en=0 afterwards ignores in but draining continues.
        en = 1'b1; in = 8'hFF; out_rdy = 1'b1;
        foreach (seqff[i]) exp_q.push_back(seqff[i]);
        step(); en = 1'b0;
        chk("ff_pend", 32'(pending), 32'hFF);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("ff_out", 32'(out), 32'(seqff[i]));
            step();
        end
        chk("ff_end_vld", 32'(out_vld), 32'h0);
        chk("ff_end_pend", 32'(pending), 32'h0);
        chk("ff_ovf", 32'(overflow), 32'h0);
        in = '0;

        step();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
